regfile_scoreboard: RTL
=======================

# regfile_scoreboard

Architectural register file plus per-register pending-write scoreboard for the 5-stage pipeline. Consumes the write-back port (write enable, 6-bit address, 32-bit data) and serves two combinational read ports to decode with same-cycle write-back bypass. Tracks in-flight writes per register from issue to write-back and raises a decode stall on read-after-write or write-count hazards.

## Interface
- No parameters; widths fixed: 32-bit data, 6-bit address (0–31 integer, 32–63 floating-point).
- clk  in  1  clock, all state updates on rising edge.
- reset  in  1  asynchronous, active-high.
- WBWE  in  1  write-back write enable.
- WBAddr  in  6  write-back destination register.
- WBData  in  32  write-back data.
- RdAddrA / RdAddrB  in  6  decode source register addresses.
- UseA / UseB  in  1  source operand A/B actually consumed by the decoding instruction.
- IssueValid  in  1  decode instruction leaves decode this cycle, if not stalled.
- IssueWE  in  1  issuing instruction writes a register.
- IssueAddr  in  6  issuing instruction's destination.
- RdDataA / RdDataB  out  32  read data, combinational.
- Stall  out  1  decode must hold, combinational.
- ErrUnderflow  out  1  sticky: write-back seen to a register with zero pending count.

## Operation
- Storage: 64 x 32-bit registers; per-register 2-bit pending count `cnt[r]` (0–3).
- Register 0: reads return 0; writes ignored; never pending (`cnt[0]` stays 0, issues to 0 do not count).
- Write: on clk edge, if WBWE and WBAddr != 0, reg[WBAddr] <= WBData.
- Read (per port X): if RdAddrX == 0 -> 0; else if WBWE and WBAddr == RdAddrX -> WBData (bypass); else reg[RdAddrX].
- Effective busy, per port: BusyX = UseX and RdAddrX != 0 and cnt[RdAddrX] != 0, excluding the case cnt == 1 and WBWE and WBAddr == RdAddrX (last pending write lands this cycle; bypass supplies data).
- Overflow hazard: OvfHaz = IssueValid and IssueWE and IssueAddr != 0 and cnt[IssueAddr] == 3.
- Stall = BusyA or BusyB or OvfHaz.
- Issue accepted (Inc) = IssueValid and IssueWE and IssueAddr != 0 and not Stall.
- Retire (Dec) = WBWE and WBAddr != 0 and cnt[WBAddr] != 0.
- Count update per register r: +1 if Inc targets r and no Dec on r; −1 if Dec on r and no Inc on r; unchanged if both or neither.
- Underflow: WBWE and WBAddr != 0 and cnt[WBAddr] == 0 -> data still written, count stays 0, ErrUnderflow set; cleared only by reset.
- IssueValid with IssueWE = 0 never changes counts but still subject to BusyA/BusyB for Stall.

## Timing
- Reset (async): all 64 registers = 0, all cnt = 0, ErrUnderflow = 0. Outputs during reset: RdDataA/B = 0 unless bypassed by WBWE (bypass path is combinational and stays active), Stall = 0 unless OvfHaz impossible (cnt all 0) -> Stall = 0.
- Reset mid-operation clears all pending counts; in-flight write-backs after reset trigger ErrUnderflow; this is expected and is masked by pipeline flush.
- Read latency 0 (combinational); write visible via bypass in the same cycle, via storage from the next cycle.
- Count changes take effect on the edge; Stall is evaluated from pre-edge counts plus same-cycle write-back.
- Issue and write-back to the same register in the same cycle: count unchanged, data written, Stall computed on old count.
- Only one issue and one write-back per cycle.

## Test plan
- Reset then read r5, r40 -> RdDataA = 0, RdDataB = 0, Stall = 0, ErrUnderflow = 0.
- WBWE=1, WBAddr=7, WBData=0xDEADBEEF with RdAddrA=7 same cycle -> RdDataA = 0xDEADBEEF (bypass); next cycle WBWE=0 -> still 0xDEADBEEF.
- Write r0 = 0x12345678, read r0 -> 0; issue to r0 -> no Stall ever, cnt[0] = 0.
- Issue to r9 (cnt 1), next cycle UseA=1, RdAddrA=9 -> Stall = 1; cycle with WBWE to r9 data 0x55 -> Stall = 0, RdDataA = 0x55; cnt[9] = 0 after edge.
- Issue to r33 three times (cnt 3), fourth IssueValid/IssueWE to r33 -> Stall = 1, cnt stays 3; same cycle write-back to r33 -> still Stall = 1 (old count), then cnt = 2.
- WBWE to r12 with cnt[12] = 0 -> reg written, ErrUnderflow = 1 and stays 1 until reset pulse clears it asynchronously.

Source files
------------

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard
//   Architectural register file (64 x 32-bit, r0 hardwired to zero) with a
//   per-register pending-write counter. Decode stalls on read-after-write
//   hazards and when a destination already has three writes in flight.
//
// Ports
//   clk, reset               clock (rising edge), asynchronous active-high reset
//   WBWE, WBAddr, WBData     write-back port
//   RdAddrA/B, UseA/B        decode source operands
//   IssueValid/WE/Addr       instruction leaving decode and its destination
//   RdDataA/B                combinational read data with write-back bypass
//   Stall                    combinational decode hold
//   ErrUnderflow             sticky: write-back to a register with no pending write
module regfile_scoreboard (
    input  logic        clk,
    input  logic        reset,
    input  logic        WBWE,
    input  logic [5:0]  WBAddr,
    input  logic [31:0] WBData,
    input  logic [5:0]  RdAddrA,
    input  logic [5:0]  RdAddrB,
    input  logic        UseA,
    input  logic        UseB,
    input  logic        IssueValid,
    input  logic        IssueWE,
    input  logic [5:0]  IssueAddr,
    output logic [31:0] RdDataA,
    output logic [31:0] RdDataB,
    output logic        Stall,
    output logic        ErrUnderflow
);

    logic [31:0] regs_q [64];
    logic [31:0] regs_d [64];
    logic [1:0]  cnt_q  [64];
    logic [1:0]  cnt_d  [64];
    logic        err_q, err_d;

    logic wb_nz;
    logic busy_a, busy_b, ovf_haz;
    logic inc, dec, underflow;

    assign wb_nz = WBWE && (WBAddr != 6'd0);

    // Read ports: r0 is zero, a same-cycle write-back is forwarded.
    always_comb begin
        if (RdAddrA == 6'd0)                   RdDataA = 32'd0;
        else if (WBWE && (WBAddr == RdAddrA))  RdDataA = WBData;
        else                                   RdDataA = regs_q[RdAddrA];

        if (RdAddrB == 6'd0)                   RdDataB = 32'd0;
        else if (WBWE && (WBAddr == RdAddrB))  RdDataB = WBData;
        else                                   RdDataB = regs_q[RdAddrB];
    end

    // A source stays busy unless its only outstanding write lands this cycle.
    always_comb begin
        busy_a = UseA && (RdAddrA != 6'd0) && (cnt_q[RdAddrA] != 2'd0) &&
                 !((cnt_q[RdAddrA] == 2'd1) && WBWE && (WBAddr == RdAddrA));
        busy_b = UseB && (RdAddrB != 6'd0) && (cnt_q[RdAddrB] != 2'd0) &&
                 !((cnt_q[RdAddrB] == 2'd1) && WBWE && (WBAddr == RdAddrB));
        ovf_haz = IssueValid && IssueWE && (IssueAddr != 6'd0) &&
                  (cnt_q[IssueAddr] == 2'd3);
    end

    assign Stall        = busy_a || busy_b || ovf_haz;
    assign inc          = IssueValid && IssueWE && (IssueAddr != 6'd0) && !Stall;
    assign dec          = wb_nz && (cnt_q[WBAddr] != 2'd0);
    assign underflow    = wb_nz && (cnt_q[WBAddr] == 2'd0);
    assign ErrUnderflow = err_q;

    always_comb begin
        regs_d = regs_q;
        cnt_d  = cnt_q;
        err_d  = err_q || underflow;
        if (wb_nz) begin
            regs_d[WBAddr] = WBData;
        end
        // Issue and retire to the same register cancel out.
        if (inc && !(dec && (WBAddr == IssueAddr))) begin
            cnt_d[IssueAddr] = cnt_q[IssueAddr] + 2'd1;
        end
        if (dec && !(inc && (WBAddr == IssueAddr))) begin
            cnt_d[WBAddr] = cnt_q[WBAddr] - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 64; i++) begin
                regs_q[i] <= 32'd0;
                cnt_q[i]  <= 2'd0;
            end
            err_q <= 1'b0;
        end else begin
            regs_q <= regs_d;
            cnt_q  <= cnt_d;
            err_q  <= err_d;
        end
    end

endmodule
